// File: rtl/mask_pkg.sv
// Shared constants for the mask overlay: register map offsets, limits and
// the coordinate index used to address the per-rectangle coordinate banks.
package mask_pkg;

  // Register map, relative to the block's base address.
  localparam int         RECT_STRIDE  = 8;
  localparam logic [7:0] OFS_EN       = 8'h20;
  localparam logic [7:0] OFS_FILL_L   = 8'h21;
  localparam logic [7:0] OFS_FILL_H   = 8'h22;
  localparam int         WINDOW_BYTES = 35;

  // Limits and defaults.
  localparam int MAX_NUM_RECT = 4;
  localparam int DEFAULT_CW   = 11;

  // Each rectangle holds four coordinates; the register map stores them in
  // this order, two bytes apiece.
  typedef enum logic [1:0] {
    COORD_X0 = 2'd0,
    COORD_Y0 = 2'd1,
    COORD_X1 = 2'd2,
    COORD_Y1 = 2'd3
  } coord_e;

endpackage

// File: rtl/mask_rect_cmp.sv
// Combinational hit test of one pixel position against one mask rectangle.
module mask_rect_cmp
  import mask_pkg::*;
#(
  parameter int CW = DEFAULT_CW
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  input  logic          en,
  output logic          hit
);

  // Inclusive unsigned box test; an inverted box (x0>x1 or y0>y1) cannot
  // satisfy both sides of its comparison pair, so it never hits.
  assign hit = en & (x >= x0) & (x <= x1) & (y >= y0) & (y <= y1);

endmodule

// File: rtl/mask_overlay.sv
// Privacy-mask overlay on a DVP-style RGB565 stream. Up to four rectangles
// are programmed through a byte-wide register window into staging registers,
// copied to the active bank at each frame start, and pixels inside any
// enabled active rectangle are replaced by the fill colour. All outputs are
// a one-cycle registered copy of the input stream.
module mask_overlay
  import mask_pkg::*;
#(
  parameter int         NUM_RECT  = 4,
  parameter int         CW        = DEFAULT_CW,
  parameter logic [7:0] ADDR_BASE = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  reg_data,
  input  logic        reg_wr,
  input  logic        vsync_i,
  input  logic        href_i,
  input  logic        valid_i,
  input  logic [15:0] data_i,
  output logic        vsync_o,
  output logic        href_o,
  output logic        valid_o,
  output logic [15:0] data_o
);

  localparam logic [CW-1:0] CMAX = '1;

  // Register decode. The offset is formed one bit wider than the address so
  // that addresses below the base wrap far above the window and are rejected
  // by the same range compare.
  logic [8:0] w_ofs;
  logic       w_in_win;
  logic       w_wr_rect;
  logic       w_wr_en;
  logic       w_wr_fill_l;
  logic       w_wr_fill_h;

  assign w_ofs       = {1'b0, reg_addr} - {1'b0, ADDR_BASE};
  assign w_in_win    = reg_wr & (w_ofs < 9'(WINDOW_BYTES));
  assign w_wr_rect   = w_in_win & (w_ofs < {1'b0, OFS_EN});
  assign w_wr_en     = w_in_win & (w_ofs == {1'b0, OFS_EN});
  assign w_wr_fill_l = w_in_win & (w_ofs == {1'b0, OFS_FILL_L});
  assign w_wr_fill_h = w_in_win & (w_ofs == {1'b0, OFS_FILL_H});

  // Staging bank (written by software) and active bank (used by the datapath).
  logic [CW-1:0]       r_stg [NUM_RECT][4];
  logic [CW-1:0]       r_act [NUM_RECT][4];
  logic [NUM_RECT-1:0] r_stg_en;
  logic [NUM_RECT-1:0] r_act_en;
  logic [15:0]         r_stg_fill;
  logic [15:0]         r_act_fill;

  // Edge detection and position counters.
  logic          r_vsync_d;
  logic          r_href_d;
  logic          w_vs_rise;
  logic          w_href_rise;
  logic          w_href_fall;
  logic [CW-1:0] r_x_next;  // column the next valid pixel on this line will take
  logic [CW-1:0] w_x;       // column of the pixel presented this cycle
  logic [CW-1:0] r_y;

  assign w_vs_rise   = vsync_i & ~r_vsync_d;
  assign w_href_rise = href_i & ~r_href_d;
  assign w_href_fall = ~href_i & r_href_d;
  assign w_x         = w_href_rise ? '0 : r_x_next;

  // Software writes land in staging; rectangles beyond NUM_RECT fall outside
  // the loop and are dropped, and unused high bits of a byte are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every staging entry is reset, not just the enables: these are a
      // handful of flops (not RAM), and stale coordinates must never reach the
      // active bank after a reset.
      for (int k = 0; k < NUM_RECT; k++) begin
        for (int c = 0; c < 4; c++) begin
          r_stg[k][c] <= '0;
        end
      end
      r_stg_en   <= '0;
      r_stg_fill <= '0;
    end else begin
      for (int k = 0; k < NUM_RECT; k++) begin
        for (int c = 0; c < 4; c++) begin
          if (w_wr_rect && (w_ofs[4:3] == 2'(k)) && (w_ofs[2:1] == 2'(c))) begin
            if (w_ofs[0]) begin
              r_stg[k][c][CW-1:8] <= reg_data[CW-9:0];
            end else begin
              r_stg[k][c][7:0] <= reg_data;
            end
          end
        end
      end
      if (w_wr_en)     r_stg_en         <= reg_data[NUM_RECT-1:0];
      if (w_wr_fill_l) r_stg_fill[7:0]  <= reg_data;
      if (w_wr_fill_h) r_stg_fill[15:8] <= reg_data;
    end
  end

  // Frame-start shadow copy: a write in the copy cycle still only reaches
  // staging, so it waits for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_RECT; k++) begin
        for (int c = 0; c < 4; c++) begin
          r_act[k][c] <= '0;
        end
      end
      r_act_en   <= '0;
      r_act_fill <= '0;
    end else if (w_vs_rise) begin
      r_act      <= r_stg;
      r_act_en   <= r_stg_en;
      r_act_fill <= r_stg_fill;
    end
  end

  // Sync edge detectors and saturating column/line counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
      r_x_next  <= '0;
      r_y       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout clocked logic, so every
      // register samples pre-edge values regardless of statement order.
      r_vsync_d <= vsync_i;
      r_href_d  <= href_i;
      if (valid_i) begin
        r_x_next <= (w_x == CMAX) ? w_x : w_x + 1'b1;
      end else begin
        r_x_next <= w_x;
      end
      if (w_vs_rise) begin
        r_y <= '0;
      end else if (w_href_fall && (r_y != CMAX)) begin
        r_y <= r_y + 1'b1;
      end
    end
  end

  // One comparator per rectangle against the active bank.
  logic [NUM_RECT-1:0] w_hit;

  for (genvar k = 0; k < NUM_RECT; k++) begin : g_rect
    mask_rect_cmp #(
      .CW (CW)
    ) u_cmp (
      .x   (w_x),
      .y   (r_y),
      .x0  (r_act[k][COORD_X0]),
      .y0  (r_act[k][COORD_Y0]),
      .x1  (r_act[k][COORD_X1]),
      .y1  (r_act[k][COORD_Y1]),
      .en  (r_act_en[k]),
      .hit (w_hit[k])
    );
  end

  // Output register: syncs and pixel travel together with one cycle latency.
  logic        r_vsync_o;
  logic        r_href_o;
  logic        r_valid_o;
  logic [15:0] r_data_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_o <= 1'b0;
      r_href_o  <= 1'b0;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
    end else begin
      r_vsync_o <= vsync_i;
      r_href_o  <= href_i;
      r_valid_o <= valid_i;
      r_data_o  <= (valid_i && (|w_hit)) ? r_act_fill : data_i;
    end
  end

  assign vsync_o = r_vsync_o;
  assign href_o  = r_href_o;
  assign valid_o = r_valid_o;
  assign data_o  = r_data_o;

endmodule

// File: tb/tb_mask_overlay.sv
// Self-checking bench for mask_overlay: scripted frames with boundary probes,
// multi-cycle corner sequences (shadow timing, mid-frame reset) and
// randomized frames, all compared cycle by cycle against a frame-level model.
module tb_mask_overlay;

  localparam int         NUM_RECT  = 4;
  localparam int         CW        = 11;
  localparam logic [7:0] ADDR_BASE = 8'h40;

  logic        clk;
  logic        rst;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        reg_wr;
  logic        vsync_i;
  logic        href_i;
  logic        valid_i;
  logic [15:0] data_i;
  logic        vsync_o;
  logic        href_o;
  logic        valid_o;
  logic [15:0] data_o;

  mask_overlay #(
    .NUM_RECT  (NUM_RECT),
    .CW        (CW),
    .ADDR_BASE (ADDR_BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .reg_wr   (reg_wr),
    .vsync_i  (vsync_i),
    .href_i   (href_i),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .vsync_o  (vsync_o),
    .href_o   (href_o),
    .valid_o  (valid_o),
    .data_o   (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (register file + frame rules) --------
  int m_stg [NUM_RECT][4];
  int m_act [NUM_RECT][4];
  int m_stg_en, m_act_en, m_stg_fill, m_act_fill;
  bit m_vs_prev;

  function automatic void m_clear();
    for (int k = 0; k < NUM_RECT; k++)
      for (int c = 0; c < 4; c++) begin
        m_stg[k][c] = 0;
        m_act[k][c] = 0;
      end
    m_stg_en = 0; m_act_en = 0; m_stg_fill = 0; m_act_fill = 0;
    m_vs_prev = 0;
  endfunction

  function automatic void m_write(input logic [7:0] wa, input logic [7:0] wd);
    int ofs, k, c, d;
    ofs = int'(wa) - int'(ADDR_BASE);
    d = int'(wd);
    if (ofs < 0 || ofs >= 35) return;
    if (ofs < 32) begin
      k = ofs / 8;
      if (k >= NUM_RECT) return;
      c = (ofs % 8) / 2;
      if (ofs % 2 == 1)
        m_stg[k][c] = (m_stg[k][c] & 255) | ((d & ((1 << (CW - 8)) - 1)) << 8);
      else
        m_stg[k][c] = (m_stg[k][c] & ~255) | d;
    end else if (ofs == 32) m_stg_en = d & ((1 << NUM_RECT) - 1);
    else if (ofs == 33)     m_stg_fill = (m_stg_fill & 'hFF00) | d;
    else                    m_stg_fill = (m_stg_fill & 'h00FF) | (d << 8);
  endfunction

  function automatic bit m_hit(input int x, input int y);
    for (int k = 0; k < NUM_RECT; k++)
      if (((m_act_en >> k) & 1) == 1 && x >= m_act[k][0] && x <= m_act[k][2] &&
          y >= m_act[k][1] && y <= m_act[k][3])
        return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus; the DUT output for these inputs is compared one
  // cycle later (sampled 1 time unit after the edge).
  task automatic step(input bit r, input bit vs, input bit hr, input bit va,
                      input logic [15:0] d, input int col, input int line,
                      input bit we, input logic [7:0] wa, input logic [7:0] wd,
                      output logic [15:0] dout);
    logic [18:0] exp_v;
    if (r) exp_v = '0;
    else   exp_v = {vs, hr, va, (va && m_hit(col, line)) ? 16'(m_act_fill) : d};
    rst = r; vsync_i = vs; href_i = hr; valid_i = va; data_i = d;
    reg_wr = we; reg_addr = wa; reg_data = wd;
    if (r) m_clear();
    else begin
      if (vs && !m_vs_prev) begin
        m_act = m_stg; m_act_en = m_stg_en; m_act_fill = m_stg_fill;
      end
      if (we) m_write(wa, wd);
      m_vs_prev = vs;
    end
    @(posedge clk); #1;
    check($sformatf("stream f%0d l%0d c%0d", frame_no, line, col),
          32'({vsync_o, href_o, valid_o, data_o}), 32'(exp_v));
    dout = data_o;
  endtask

  // ---------------- register write queues --------------------------------
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t wq[$];
  bit  vs_wr_pend = 0;
  wr_t vs_wr;

  task automatic qw(input int ofs, input int data);
    wr_t w;
    w.addr = ADDR_BASE + 8'(ofs);
    w.data = 8'(data);
    wq.push_back(w);
  endtask

  task automatic qrect(input int k, input int x0, input int y0, input int x1, input int y1);
    int v [4];
    v[0] = x0; v[1] = y0; v[2] = x1; v[3] = y1;
    for (int c = 0; c < 4; c++) begin
      qw(8 * k + 2 * c, v[c] & 255);
      qw(8 * k + 2 * c + 1, v[c] >> 8);
    end
  endtask

  // ---------------- frame generator --------------------------------------
  logic [15:0] cap [64][64];

  task automatic run_frame(input int w, input int h, input bit gaps, input bit rnd,
                           input bit do_cap, input int rst_line,
                           input logic [15:0] cnt_val, output int n_cnt);
    logic [15:0] dout, d;
    wr_t wr;
    bit  we, r;
    n_cnt = 0;
    frame_no++;
    for (int i = 0; i < 5; i++) begin
      we = 0; wr.addr = 0; wr.data = 0;
      if (i == 0 && vs_wr_pend) begin we = 1; wr = vs_wr; vs_wr_pend = 0; end
      step(0, i < 2, 0, 0, 16'($urandom), 0, 0, we, wr.addr, wr.data, dout);
    end
    for (int l = 0; l < h; l++) begin
      for (int c = 0; c < w; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          int n = $urandom_range(1, 3);
          for (int g = 0; g < n; g++)
            step(0, 0, 1, 0, 16'($urandom), c, l, 0, 8'h0, 8'h0, dout);
        end
        d = rnd ? 16'($urandom) : {8'(l), 8'(c)};
        r = (l == rst_line) && (c == 12);
        we = 0; wr.addr = 0; wr.data = 0;
        if (!r && l >= 1 && wq.size() > 0) begin wr = wq.pop_front(); we = 1; end
        step(r, 0, 1, 1, d, c, l, we, wr.addr, wr.data, dout);
        if (!r && dout == cnt_val) n_cnt++;
        if (do_cap) cap[l][c] = dout;
      end
      for (int i = 0; i < 3; i++)
        step(0, 0, 0, 0, 16'($urandom), 0, l, 0, 8'h0, 8'h0, dout);
    end
  endtask

  // ---------------- boundary probe table ---------------------------------
  typedef struct { int px; int py; logic [15:0] exp; } probe_t;
  probe_t probes [10];

  task automatic apply_probes(input string tag);
    for (int i = 0; i < 10; i++)
      check($sformatf("probe %s (%0d,%0d)", tag, probes[i].px, probes[i].py),
            32'(cap[probes[i].py][probes[i].px]), 32'(probes[i].exp));
  endtask

  initial begin
    logic [15:0] dout;
    int n;

    // Rect0 = (10,20)-(19,29), fill F800; unmasked pixels carry {line, col}.
    probes[0] = '{10, 20, 16'hF800};
    probes[1] = '{19, 29, 16'hF800};
    probes[2] = '{19, 20, 16'hF800};
    probes[3] = '{14, 25, 16'hF800};
    probes[4] = '{9,  20, 16'h1409};
    probes[5] = '{20, 20, 16'h1414};
    probes[6] = '{10, 19, 16'h130A};
    probes[7] = '{10, 30, 16'h1E0A};
    probes[8] = '{0,  0,  16'h0000};
    probes[9] = '{39, 35, 16'h2327};

    rst = 1; vsync_i = 0; href_i = 0; valid_i = 0; data_i = 0;
    reg_wr = 0; reg_addr = 0; reg_data = 0;
    m_clear();

    // Reset: outputs held at zero even with live inputs.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 16'hABCD, 0, 0, 0, 8'h0, 8'h0, dout);
    step(0, 0, 0, 0, 16'h1234, 0, 0, 0, 8'h0, 8'h0, dout);

    // Frame A: no configuration -> pure passthrough.
    run_frame(40, 36, 0, 0, 0, -1, 16'hF800, n);
    check("frame A fill count", 32'(n), 32'd0);

    // Frame B: program rect0 mid-frame; nothing changes in this frame.
    qrect(0, 10, 20, 19, 29);
    qw(32'h20, 1); qw(32'h21, 8'h00); qw(32'h22, 8'hF8);
    run_frame(40, 36, 0, 0, 0, -1, 16'hF800, n);
    check("frame B fill count", 32'(n), 32'd0);

    // Frame C: mask live, exactly the 10x10 box.
    run_frame(40, 36, 0, 0, 1, -1, 16'hF800, n);
    check("frame C fill count", 32'(n), 32'd100);
    apply_probes("gapless");

    // Frame D: disable written in the vsync-rise cycle; still masked, and
    // valid gaps must not move the mask edges.
    vs_wr.addr = ADDR_BASE + 8'h20; vs_wr.data = 8'h00; vs_wr_pend = 1;
    run_frame(40, 36, 1, 0, 1, -1, 16'hF800, n);
    check("frame D fill count", 32'(n), 32'd100);
    apply_probes("gapped");

    // Frame E: disable now active. Program inverted rect1 (x0=50 > x1=40).
    qrect(1, 50, 0, 40, 35);
    qw(32'h20, 8'h02);
    run_frame(40, 36, 0, 0, 0, -1, 16'hF800, n);
    check("frame E fill count", 32'(n), 32'd0);

    // Frame F: inverted rect never hits. Program full-frame rect2, with the
    // x1 high byte written as FF to exercise discarded bits.
    qw(16, 0); qw(17, 0); qw(18, 0); qw(19, 0);
    qw(20, 8'hFF); qw(21, 8'hFF); qw(22, 8'hFF); qw(23, 8'h07);
    qw(32'h20, 8'h06); qw(32'h21, 8'hE0); qw(32'h22, 8'h07);
    run_frame(40, 36, 0, 0, 0, -1, 16'hF800, n);
    check("frame F inverted rect count", 32'(n), 32'd0);

    // Full-frame rect: every valid pixel filled, out to column 639 / line 479.
    run_frame(640, 4, 0, 0, 0, -1, 16'h07E0, n);
    check("wide frame fill count", 32'(n), 32'd2560);
    run_frame(2, 480, 0, 0, 0, -1, 16'h07E0, n);
    check("tall frame fill count", 32'(n), 32'd960);

    // Frame H: reset at line 22 col 12; filled before, passthrough after.
    run_frame(40, 36, 0, 0, 0, 22, 16'h07E0, n);
    check("reset frame fill count", 32'(n), 32'd892);

    // Frame I: staging was cleared, so the mask does not return.
    run_frame(40, 36, 0, 0, 0, -1, 16'h07E0, n);
    check("post-reset fill count", 32'(n), 32'd0);

    // Randomized frames: random rects, fill, enables, stray writes, gaps.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < NUM_RECT; k++) begin
        int x0 = $urandom_range(0, 20), y0 = $urandom_range(0, 16);
        int x1 = x0 + $urandom_range(0, 8), y1 = y0 + $urandom_range(0, 6);
        if ($urandom_range(0, 5) == 0) x1 = x0 - 1;
        qrect(k, x0, y0, x1, y1);
      end
      qw(32'h20, $urandom_range(0, 255));
      qw(32'h21, $urandom_range(0, 255));
      qw(32'h22, $urandom_range(0, 255));
      for (int j = 0; j < 6; j++) begin
        wr_t w;
        w.addr = 8'($urandom); w.data = 8'($urandom);
        wq.push_back(w);
      end
      run_frame(24, 20, 1, 1, 0, -1, 16'h0000, n);
    end
    run_frame(24, 20, 1, 1, 0, -1, 16'h0000, n);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
